ycr_dmem_router: RTL and testbench

- Address-decoding router between the core data-memory interface and two targets: port 0 (TCM) and port 1 (external/system bus bridge).
- Sits directly upstream of the TCM dmem port.
- Forwards one request at a time using the req/req_ack plus resp handshake, remembers which port owns the outstanding transaction, and returns that port's resp/rdata.
- A new request may be issued in the same cycle the outstanding response returns.

---
 rtl/ycr_dmem_router.sv | 163 ++++++++++++++++
 tb/tb_ycr_dmem_router.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/ycr_dmem_router.sv
// Data-memory router: decodes the core dmem request to the TCM or the external bridge and
// returns the owning port's response. Optional response timeout: YCR_DMEM_ROUTER_TIMEOUT_EN.

`ifndef YCR_DMEM_AWIDTH
`define YCR_DMEM_AWIDTH 32
`endif
`ifndef YCR_DMEM_DWIDTH
`define YCR_DMEM_DWIDTH 32
`endif

module ycr_dmem_router #(
    parameter logic [`YCR_DMEM_AWIDTH-1:0] TCM_ADDR_MASK    = 32'hFFFF_F000,
    parameter logic [`YCR_DMEM_AWIDTH-1:0] TCM_ADDR_PATTERN = 32'h0C48_0000,
    parameter int unsigned                 TIMEOUT_CYCLES   = 255
) (
    input  logic                        clk,
    input  logic                        rst_n,
    // core side
    input  logic                        dmem_req,
    output logic                        dmem_req_ack,
    input  logic                        dmem_cmd,
    input  logic [1:0]                  dmem_width,
    input  logic [`YCR_DMEM_AWIDTH-1:0] dmem_addr,
    input  logic [`YCR_DMEM_DWIDTH-1:0] dmem_wdata,
    output logic [`YCR_DMEM_DWIDTH-1:0] dmem_rdata,
    output logic [1:0]                  dmem_resp,
    // port 0: TCM
    output logic                        tcm_req,
    input  logic                        tcm_req_ack,
    output logic                        tcm_cmd,
    output logic [1:0]                  tcm_width,
    output logic [`YCR_DMEM_AWIDTH-1:0] tcm_addr,
    output logic [`YCR_DMEM_DWIDTH-1:0] tcm_wdata,
    input  logic [`YCR_DMEM_DWIDTH-1:0] tcm_rdata,
    input  logic [1:0]                  tcm_resp,
    // port 1: external bridge
    output logic                        ext_req,
    input  logic                        ext_req_ack,
    output logic                        ext_cmd,
    output logic [1:0]                  ext_width,
    output logic [`YCR_DMEM_AWIDTH-1:0] ext_addr,
    output logic [`YCR_DMEM_DWIDTH-1:0] ext_wdata,
    input  logic [`YCR_DMEM_DWIDTH-1:0] ext_rdata,
    input  logic [1:0]                  ext_resp
);

    localparam logic [1:0] RespNotRdy = 2'b00;
    localparam logic [1:0] RespOk     = 2'b01;
    localparam logic [1:0] RespEr     = 2'b10;

    // The timeout counter is 8 bits wide, so larger limits could never be reached.
    if (TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must fit in 8 bits");
    end

    typedef enum logic [1:0] {StIdle, StWait, StFlush} state_e;

    state_e                       state_q, state_d;
    logic                         port_sel_q, port_sel_d;
    logic                         sel;
    logic                         resp_done;
    logic                         issue_ok;
    logic                         accept;
    logic [1:0]                   own_resp;
    logic [`YCR_DMEM_DWIDTH-1:0]  own_rdata;

`ifdef YCR_DMEM_ROUTER_TIMEOUT_EN
    localparam logic [7:0] TimeoutLimit = 8'(TIMEOUT_CYCLES);
    logic [7:0] cnt_q, cnt_d;
`endif

    assign sel       = ((dmem_addr & TCM_ADDR_MASK) != TCM_ADDR_PATTERN);
    assign own_resp  = port_sel_q ? ext_resp : tcm_resp;
    assign own_rdata = port_sel_q ? ext_rdata : tcm_rdata;
    assign resp_done = (state_q == StWait) && (own_resp != RespNotRdy);
    assign issue_ok  = (state_q == StIdle) || resp_done;

    assign tcm_req      = dmem_req & issue_ok & ~sel;
    assign ext_req      = dmem_req & issue_ok & sel;
    assign dmem_req_ack = issue_ok & (sel ? ext_req_ack : tcm_req_ack);
    assign accept       = dmem_req & dmem_req_ack;

    assign tcm_cmd   = dmem_cmd;
    assign tcm_width = dmem_width;
    assign tcm_addr  = dmem_addr;
    assign tcm_wdata = dmem_wdata;
    assign ext_cmd   = dmem_cmd;
    assign ext_width = dmem_width;
    assign ext_addr  = dmem_addr;
    assign ext_wdata = dmem_wdata;

    always_comb begin
        state_d    = state_q;
        port_sel_d = port_sel_q;
        dmem_resp  = RespNotRdy;
        dmem_rdata = '0;
`ifdef YCR_DMEM_ROUTER_TIMEOUT_EN
        cnt_d      = cnt_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    port_sel_d = sel;
                    state_d    = StWait;
`ifdef YCR_DMEM_ROUTER_TIMEOUT_EN
                    cnt_d      = '0;
`endif
                end
            end
            StWait: begin
                if (resp_done) begin
                    dmem_resp  = own_resp;
                    dmem_rdata = (own_resp == RespOk) ? own_rdata : '0;
                    // A request accepted on the response cycle keeps the router busy.
                    if (accept) begin
                        port_sel_d = sel;
`ifdef YCR_DMEM_ROUTER_TIMEOUT_EN
                        cnt_d      = '0;
`endif
                    end else begin
                        state_d = StIdle;
                    end
                end
`ifdef YCR_DMEM_ROUTER_TIMEOUT_EN
                else if (cnt_q == TimeoutLimit) begin
                    dmem_resp = RespEr;
                    state_d   = StFlush;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
`endif
            end
            StFlush: begin
                // Late response from the owning port is swallowed.
                if (own_resp != RespNotRdy) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            port_sel_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            port_sel_q <= port_sel_d;
        end
    end

`ifdef YCR_DMEM_ROUTER_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_ycr_dmem_router.sv
// Bench for ycr_dmem_router: directed scenarios then random traffic, all checked against a
// transaction-level model (one outstanding owner, optional timeout age).

`ifndef YCR_DMEM_AWIDTH
`define YCR_DMEM_AWIDTH 32
`endif
`ifndef YCR_DMEM_DWIDTH
`define YCR_DMEM_DWIDTH 32
`endif

module tb_ycr_dmem_router;

`ifdef YCR_DMEM_ROUTER_TIMEOUT_EN
    localparam int unsigned TMO = 4;
`else
    localparam int unsigned TMO = 255;
`endif
    localparam logic [31:0] TA = 32'h0C48_0010;
    localparam logic [31:0] EA = 32'h1000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        dmem_req = 1'b0, dmem_cmd = 1'b0;
    logic [1:0]  dmem_width = 2'd0;
    logic [31:0] dmem_addr = '0, dmem_wdata = '0;
    logic        dmem_req_ack;
    logic [31:0] dmem_rdata;
    logic [1:0]  dmem_resp;
    logic        tcm_req, tcm_req_ack = 1'b0, tcm_cmd;
    logic [1:0]  tcm_width, tcm_resp = 2'd0;
    logic [31:0] tcm_addr, tcm_wdata, tcm_rdata = '0;
    logic        ext_req, ext_req_ack = 1'b0, ext_cmd;
    logic [1:0]  ext_width, ext_resp = 2'd0;
    logic [31:0] ext_addr, ext_wdata, ext_rdata = '0;

    always #5 clk = ~clk;

    ycr_dmem_router #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .dmem_req(dmem_req), .dmem_req_ack(dmem_req_ack), .dmem_cmd(dmem_cmd),
        .dmem_width(dmem_width), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
        .tcm_req(tcm_req), .tcm_req_ack(tcm_req_ack), .tcm_cmd(tcm_cmd),
        .tcm_width(tcm_width), .tcm_addr(tcm_addr), .tcm_wdata(tcm_wdata),
        .tcm_rdata(tcm_rdata), .tcm_resp(tcm_resp),
        .ext_req(ext_req), .ext_req_ack(ext_req_ack), .ext_cmd(ext_cmd),
        .ext_width(ext_width), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
        .ext_rdata(ext_rdata), .ext_resp(ext_resp)
    );

    int total = 0;
    int bad   = 0;

    // Model: ports owning an outstanding transaction (at most one), its age, flush flag.
    int owner_q[$];
    int age = 0;
    bit flushing = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic req, input logic cmd, input logic [1:0] w,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic tack, input logic eack,
                        input logic [1:0] tr, input logic [1:0] er,
                        input logic [31:0] trd, input logic [31:0] erd);
        bit          to_ext, can, tmo, ack;
        logic [1:0]  pr, exp_resp;
        logic [31:0] prd, exp_rd;
        @(negedge clk);
        dmem_req = req; dmem_cmd = cmd; dmem_width = w; dmem_addr = a; dmem_wdata = wd;
        tcm_req_ack = tack; ext_req_ack = eack; tcm_resp = tr; ext_resp = er;
        tcm_rdata = trd; ext_rdata = erd;
        #1;
        to_ext   = !(a >= 32'h0C48_0000 && a < 32'h0C48_1000);
        can      = 1'b1;
        tmo      = 1'b0;
        exp_resp = 2'b00;
        exp_rd   = '0;
        pr       = 2'b00;
        prd      = '0;
        if (owner_q.size() != 0) begin
            pr  = (owner_q[0] == 1) ? er : tr;
            prd = (owner_q[0] == 1) ? erd : trd;
            if (flushing) begin
                can = 1'b0;
            end else if (pr != 2'b00) begin
                exp_resp = pr;
                exp_rd   = (pr == 2'b01) ? prd : 32'h0;
            end else begin
                can = 1'b0;
`ifdef YCR_DMEM_ROUTER_TIMEOUT_EN
                if (age == int'(TMO)) begin
                    tmo      = 1'b1;
                    exp_resp = 2'b10;
                end
`endif
            end
        end
        ack = can && (to_ext ? eack : tack);
        chk("tcm_req", {31'h0, tcm_req}, {31'h0, req && can && !to_ext});
        chk("ext_req", {31'h0, ext_req}, {31'h0, req && can && to_ext});
        chk("dmem_req_ack", {31'h0, dmem_req_ack}, {31'h0, ack});
        chk("dmem_resp", {30'h0, dmem_resp}, {30'h0, exp_resp});
        chk("dmem_rdata", dmem_rdata, exp_rd);
        chk("tcm_addr", tcm_addr, a);
        chk("ext_addr", ext_addr, a);
        chk("tcm_wdata", tcm_wdata, wd);
        chk("ext_wdata", ext_wdata, wd);
        chk("cmd_width", {26'h0, tcm_cmd, tcm_width, ext_cmd, ext_width},
            {26'h0, cmd, w, cmd, w});
        if (owner_q.size() != 0) begin
            if (flushing) begin
                if (pr != 2'b00) begin
                    owner_q.delete();
                    flushing = 1'b0;
                end
            end else if (pr != 2'b00) begin
                owner_q.delete();
            end else if (tmo) begin
                flushing = 1'b1;
            end else begin
                age++;
            end
        end
        if (req && ack) begin
            owner_q.push_back(int'(to_ext));
            age = 0;
        end
        @(posedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        dmem_req = 1'b0; dmem_cmd = 1'b0; dmem_width = 2'd0; dmem_addr = EA; dmem_wdata = '0;
        tcm_req_ack = 1'b0; ext_req_ack = 1'b0;
        tcm_resp = 2'b01; ext_resp = 2'b01; tcm_rdata = 32'hCAFE_0001; ext_rdata = 32'hDEAD_BEEF;
        rst_n = 1'b0;
        #1;
        chk("rst_resp", {30'h0, dmem_resp}, 32'h0);
        chk("rst_rdata", dmem_rdata, 32'h0);
        chk("rst_req_ack", {31'h0, dmem_req_ack}, 32'h0);
        chk("rst_reqs", {30'h0, tcm_req, ext_req}, 32'h0);
        owner_q.delete();
        flushing = 1'b0;
        age = 0;
        @(posedge clk);
        @(negedge clk);
        tcm_resp = 2'b00; ext_resp = 2'b00;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] ra;
        logic [1:0]  rt, re;
        do_reset();

        // TCM read: ack one cycle later, data two cycles after that
        step(1, 0, 2, TA, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 2, TA, 0, 1, 0, 0, 0, 0, 0);
        step(0, 0, 2, TA, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 2, TA, 0, 0, 0, 1, 0, 32'h1234_5678, 0);
        step(0, 0, 2, TA, 0, 0, 0, 0, 0, 0, 0);

        // Ext write with a stray TCM response while waiting
        step(1, 1, 2, EA, 32'hA5A5_A5A5, 0, 1, 0, 0, 0, 0);
        step(0, 1, 2, EA, 32'hA5A5_A5A5, 0, 0, 0, 0, 0, 0);
        step(0, 1, 2, EA, 32'hA5A5_A5A5, 0, 0, 1, 0, 32'h5555_0000, 0);
        step(0, 1, 2, EA, 32'hA5A5_A5A5, 0, 0, 0, 0, 0, 0);
        step(0, 1, 2, EA, 32'hA5A5_A5A5, 0, 0, 0, 0, 0, 0);
        step(0, 1, 2, EA, 32'hA5A5_A5A5, 0, 0, 0, 1, 0, 32'h0BAD_0BAD);

        // Back-to-back TCM -> ext switch, stray TCM resp, then ext error
        step(1, 0, 2, TA, 0, 1, 0, 0, 0, 0, 0);
        step(1, 0, 2, EA, 0, 0, 1, 1, 0, 32'h8765_4321, 0);
        step(0, 0, 2, EA, 0, 0, 0, 1, 0, 32'h7777_7777, 0);
        step(0, 0, 2, EA, 0, 0, 0, 0, 2, 0, 32'hFFFF_FFFF);
        step(1, 0, 2, 32'h0C48_0FFC, 0, 0, 0, 0, 0, 0, 0);

        // Window boundaries, no acks
        step(1, 0, 0, 32'h0C48_1000, 0, 1, 0, 0, 0, 0, 0);
        step(1, 0, 1, 32'h0C47_FFFF, 0, 1, 0, 0, 0, 0, 0);
        step(1, 0, 2, 32'h0C48_0000, 0, 0, 1, 0, 0, 0, 0);

`ifdef YCR_DMEM_ROUTER_TIMEOUT_EN
        // Ext never answers; TCM request is held off until the late ext resp is dropped
        step(1, 0, 2, EA, 0, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) step(i > 2, 0, 2, TA, 0, 1, 0, 0, 0, 0, 0);
        step(1, 0, 2, TA, 0, 1, 0, 0, 1, 0, 32'h1111_2222);
        step(1, 0, 2, TA, 0, 1, 0, 0, 0, 0, 0);
        step(0, 0, 2, TA, 0, 0, 0, 1, 0, 32'h3333_4444, 0);
`endif

        // Reset while an ext transaction is outstanding, then a clean TCM read
        step(1, 0, 2, EA, 0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 2, EA, 0, 0, 0, 0, 0, 0, 0);
        do_reset();
        step(1, 0, 2, TA, 0, 1, 0, 0, 0, 0, 0);
        step(0, 0, 2, TA, 0, 0, 0, 1, 0, 32'h2468_ACE0, 0);

        // Random traffic with stray responses from both ports
        for (int i = 0; i < 800; i++) begin
            case ($urandom_range(0, 4))
                0:       ra = 32'h0C48_0000 + ($urandom & 32'hFFF);
                1:       ra = 32'h0C48_1000;
                2:       ra = 32'h0C47_FFFF;
                default: ra = $urandom;
            endcase
            rt = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 3) == 0) ? 2'b10 : 2'b01)
                                             : 2'b00;
            re = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 3) == 0) ? 2'b10 : 2'b01)
                                             : 2'b00;
            step(1'($urandom), 1'($urandom), 2'($urandom_range(0, 2)), ra, $urandom,
                 1'($urandom), 1'($urandom), rt, re, $urandom, $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
